// File: rtl/pipeline_controller_pkg.sv
// Shared pipeline-control types: FSM encodings, latch indices and the control bundle
// that the datapath top fans out to the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
package pipeline_controller_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pctl_state_t;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DWAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam int LAT_IFID  = 0;
  localparam int LAT_IDEX  = 1;
  localparam int LAT_EXMEM = 2;
  localparam int LAT_MEMWB = 3;

  typedef struct packed {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] flush;
  } pipe_ctl_t;

  // Flush wins over enable, so a latch can never be told to both load and bubble.
  function automatic pipe_ctl_t make_ctl(input logic pc_en, input logic [3:0] en,
                                         input logic [3:0] flush);
    pipe_ctl_t c;
    c.pc_en = pc_en;
    c.flush = flush;
    c.en    = en & ~flush;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter
  import pipeline_controller_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  input  logic         clear,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Count register: clear has priority, increment only below the ceiling
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_r <= {W{1'b0}};
    end else if (clear) begin
      q_r <= {W{1'b0}};
    end else if (en && (q_r != {W{1'b1}})) begin
      q_r <= q_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pipeline_controller.sv
// Five-stage pipeline sequencer: latch enables/flushes, PC enable, dcache-wait/halt FSM,
// saturating perf counters and a dcache-wait watchdog.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DWAIT_LIMIT = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             hu_stall,
  input  logic             ex_branch,
  input  logic             id_jump,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             imemREN,
  output logic             halt,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(DWAIT_LIMIT + 1);

  logic [1:0]        state_r;
  logic [1:0]        next_state_s;
  pipe_ctl_t         ctl_s;
  logic              imem_ren_s;
  logic              stall_s;
  logic              dreq_s;
  logic              dstall_s;
  logic              wait_en_s;
  logic              cycle_en_s;
  logic [WAIT_W-1:0] wait_q_s;
  logic              halt_r;
  logic              mem_timeout_r;

  assign dreq_s     = exmem_dREN | exmem_dWEN;
  assign dstall_s   = dreq_s & ~dhit;
  assign wait_en_s  = (state_r == ST_DWAIT) & dstall_s;
  assign cycle_en_s = (state_r != ST_HALTED);

  // Next state and latch controls; a frozen pipe keeps any branch/jump in its latches
  always_comb begin
    ctl_s        = make_ctl(1'b0, 4'b0000, 4'b0000);
    next_state_s = state_r;
    imem_ren_s   = 1'b0;
    stall_s      = 1'b0;
    if (RST) begin
      ctl_s        = make_ctl(1'b0, 4'b0000, 4'b1111);
      next_state_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN, ST_DWAIT: begin
          imem_ren_s = 1'b1;
          if (dstall_s) begin
            ctl_s        = make_ctl(1'b0, 4'b0000, 4'b1000);
            stall_s      = 1'b1;
            next_state_s = ST_DWAIT;
          end else if (mem_halt) begin
            ctl_s        = make_ctl(1'b0, 4'b1000, 4'b0111);
            next_state_s = ST_DRAIN;
          end else if (ex_branch) begin
            ctl_s        = make_ctl(1'b1, 4'b1100, 4'b0011);
            next_state_s = ST_RUN;
          end else if (hu_stall) begin
            ctl_s        = make_ctl(1'b0, 4'b1100, 4'b0010);
            stall_s      = 1'b1;
            next_state_s = ST_RUN;
          end else if (id_jump && ihit) begin
            ctl_s        = make_ctl(1'b1, 4'b1110, 4'b0001);
            next_state_s = ST_RUN;
          end else if (!ihit) begin
            ctl_s        = make_ctl(1'b0, 4'b1110, 4'b0001);
            stall_s      = 1'b1;
            next_state_s = ST_RUN;
          end else begin
            ctl_s        = make_ctl(1'b1, 4'b1111, 4'b0000);
            next_state_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          // memwb stays closed: the older instruction already in MEM/WB retires now
          stall_s      = 1'b1;
          next_state_s = ST_HALTED;
        end
        ST_HALTED: begin
          next_state_s = ST_HALTED;
        end
        default: begin
          next_state_s = ST_RUN;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Sticky halt flag, raised as DRAIN hands over to HALTED
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halt_r <= 1'b0;
    end else if (state_r == ST_DRAIN) begin
      halt_r <= 1'b1;
    end else begin
      halt_r <= halt_r;
    end
  end

  // Sticky watchdog flag; the wait itself is never aborted
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_timeout_r <= 1'b0;
    end else if (wait_en_s && (wait_q_s >= WAIT_W'(DWAIT_LIMIT - 1))) begin
      mem_timeout_r <= 1'b1;
    end else begin
      mem_timeout_r <= mem_timeout_r;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .en    (cycle_en_s),
    .clear (1'b0),
    .q     (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .en    (stall_s),
    .clear (1'b0),
    .q     (stall_cnt)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .en    (wait_en_s),
    .clear (~wait_en_s),
    .q     (wait_q_s)
  );

  assign pc_en       = ctl_s.pc_en;
  assign ifid_en     = ctl_s.en[LAT_IFID];
  assign idex_en     = ctl_s.en[LAT_IDEX];
  assign exmem_en    = ctl_s.en[LAT_EXMEM];
  assign memwb_en    = ctl_s.en[LAT_MEMWB];
  assign ifid_flush  = ctl_s.flush[LAT_IFID];
  assign idex_flush  = ctl_s.flush[LAT_IDEX];
  assign exmem_flush = ctl_s.flush[LAT_EXMEM];
  assign memwb_flush = ctl_s.flush[LAT_MEMWB];
  assign imemREN     = imem_ren_s;
  assign halt        = halt_r;
  assign mem_timeout = mem_timeout_r;

endmodule
